// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scoreboard of in-flight destination registers for the
// in-order pipeline. Tracks DEPTH post-ID stages (S1=EX .. S<DEPTH>=WB) and
// derives the fetch/decode stall, the WB-to-ID bypass selects and the
// registered EX-stage forwarding selects.
// Optional feature macro: HAZARD_FORWARDING_EN
//   defined   : forward from any stage, stall only on load-use.
//   undefined : EX forwarding selects tied to 0, stall while any producer of a
//               used source sits in S1..S<DEPTH-1>; WB-to-ID bypass still used.
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int REG_W      = 5,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             id_bypass_rs1,
    output logic             id_bypass_rs2,
    output logic [SEL_W-1:0] ex_fwd_rs1,
    output logic [SEL_W-1:0] ex_fwd_rs2,
    output logic [DEPTH-1:0] inflight,
    output logic [31:0]      stall_cnt
);

    // Scoreboard entries: index k-1 holds stage S<k>.
    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] r_ld;
    logic [REG_W-1:0] r_rd [DEPTH];
    logic [31:0]      r_stall_cnt;

    // Youngest-producer search results; stage is 1-based (0 = no match).
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_rs1_ld;
    logic             w_rs2_ld;
    logic [SEL_W-1:0] w_rs1_stage;
    logic [SEL_W-1:0] w_rs2_stage;
    logic             w_hazard;
    logic             w_stall;
    logic             w_issue;
    logic             w_new_v;

    // Find the youngest in-flight producer of each used source; the scan runs
    // oldest to youngest so a lower stage overwrites a higher one.
    always_comb begin
        // NOTE: defaults are assigned before the loop so every path writes
        // every output of this block and no latch is inferred.
        w_rs1_hit   = 1'b0;
        w_rs1_ld    = 1'b0;
        w_rs1_stage = '0;
        w_rs2_hit   = 1'b0;
        w_rs2_ld    = 1'b0;
        w_rs2_stage = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (id_rs1_used && r_v[k] && (r_rd[k] == id_rs1)) begin
                w_rs1_hit   = 1'b1;
                w_rs1_ld    = r_ld[k];
                w_rs1_stage = SEL_W'(k + 1);
            end
            if (id_rs2_used && r_v[k] && (r_rd[k] == id_rs2)) begin
                w_rs2_hit   = 1'b1;
                w_rs2_ld    = r_ld[k];
                w_rs2_stage = SEL_W'(k + 1);
            end
        end
    end

`ifdef HAZARD_FORWARDING_EN
    // Only a load whose data is not yet on a stage output blocks issue.
    assign w_hazard = (w_rs1_hit && w_rs1_ld && (w_rs1_stage < SEL_W'(LOAD_STAGE))) ||
                      (w_rs2_hit && w_rs2_ld && (w_rs2_stage < SEL_W'(LOAD_STAGE)));
`else
    // Without forwarding any producer short of WB blocks issue.
    assign w_hazard = (w_rs1_hit && (w_rs1_stage < SEL_W'(DEPTH))) ||
                      (w_rs2_hit && (w_rs2_stage < SEL_W'(DEPTH)));
`endif

    // A redirect kills the ID instruction, so it never waits on a hazard.
    assign w_stall = id_valid && !flush && w_hazard;
    assign w_issue = id_valid && !w_stall && !flush;
    // x0 and non-writing instructions never become visible producers.
    assign w_new_v = w_issue && id_reg_write && (id_rd != '0);

    assign stall         = w_stall;
    assign id_bypass_rs1 = w_rs1_hit && (w_rs1_stage == SEL_W'(DEPTH));
    assign id_bypass_rs2 = w_rs2_hit && (w_rs2_stage == SEL_W'(DEPTH));
    assign inflight      = r_v;
    assign stall_cnt     = r_stall_cnt;

    // Valid bits shift one stage per edge; a bubble enters S1 when nothing issues.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset) begin
            r_v <= '0;
        end else begin
            r_v <= {r_v[DEPTH-2:0], w_new_v};
        end
    end

    // Destination and load tags travel alongside their valid bits.
    always_ff @(posedge clk) begin
        // NOTE: tag storage is not reset; r_v qualifies every use of it.
        r_rd[0] <= id_rd;
        for (int k = 1; k < DEPTH; k++) begin
            r_rd[k] <= r_rd[k-1];
        end
        r_ld <= {r_ld[DEPTH-2:0], id_is_load};
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic [SEL_W-1:0] r_fwd_rs1;
    logic [SEL_W-1:0] r_fwd_rs2;

    // Forward selects are latched on the issuing edge: a producer at S<k> will
    // be at S<k+1> when the consumer reaches EX. A WB match is served by the
    // ID bypass instead, and bubbles carry 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fwd_rs1 <= '0;
            r_fwd_rs2 <= '0;
        end else begin
            r_fwd_rs1 <= (w_issue && w_rs1_hit && (w_rs1_stage < SEL_W'(DEPTH)))
                         ? w_rs1_stage + SEL_W'(1) : '0;
            r_fwd_rs2 <= (w_issue && w_rs2_hit && (w_rs2_stage < SEL_W'(DEPTH)))
                         ? w_rs2_stage + SEL_W'(1) : '0;
        end
    end

    assign ex_fwd_rs1 = r_fwd_rs1;
    assign ex_fwd_rs2 = r_fwd_rs2;
`else
    logic w_unused_ld;

    // Load tags only matter when forwarding; EX always takes the ID/EX operand.
    assign w_unused_ld = w_rs1_ld | w_rs2_ld;
    assign ex_fwd_rs1  = '0;
    assign ex_fwd_rs2  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: random-stimulus bench for hazard_scoreboard. Two
// instances (DEPTH=3/LOAD_STAGE=2 and DEPTH=5/LOAD_STAGE=3) share the ID
// inputs. The reference model keeps a per-cycle history of issue decisions;
// a producer's stage is simply its age in cycles since it issued.
module tb_hazard_scoreboard;

    localparam int D_A  = 3;
    localparam int L_A  = 2;
    localparam int D_B  = 5;
    localparam int L_B  = 3;
    localparam int SW_A = $clog2(D_A + 1);
    localparam int SW_B = $clog2(D_B + 1);
    localparam int NCYC = 2500;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic reset;
    logic id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic id_rs1_used;
    logic id_rs2_used;
    logic [4:0] id_rd;
    logic id_reg_write;
    logic id_is_load;
    logic flush;

    logic            stall_a, byp1_a, byp2_a;
    logic [SW_A-1:0] fwd1_a, fwd2_a;
    logic [D_A-1:0]  inflight_a;
    logic [31:0]     cnt_a;
    logic            stall_b, byp1_b, byp2_b;
    logic [SW_B-1:0] fwd1_b, fwd2_b;
    logic [D_B-1:0]  inflight_b;
    logic [31:0]     cnt_b;

    hazard_scoreboard #(.DEPTH(D_A), .LOAD_STAGE(L_A)) u_dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .flush(flush), .stall(stall_a),
        .id_bypass_rs1(byp1_a), .id_bypass_rs2(byp2_a),
        .ex_fwd_rs1(fwd1_a), .ex_fwd_rs2(fwd2_a),
        .inflight(inflight_a), .stall_cnt(cnt_a)
    );

    hazard_scoreboard #(.DEPTH(D_B), .LOAD_STAGE(L_B)) u_dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .flush(flush), .stall(stall_b),
        .id_bypass_rs1(byp1_b), .id_bypass_rs2(byp2_b),
        .ex_fwd_rs1(fwd1_b), .ex_fwd_rs2(fwd2_b),
        .inflight(inflight_b), .stall_cnt(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One record per cycle and instance: did the ID instruction of that cycle
    // enter the pipeline as a real producer, and of what.
    typedef struct packed {
        logic       wr;
        logic [4:0] rd;
        logic       ld;
    } rec_t;

    rec_t        hist [2][NCYC];
    int          cyc;
    int          valid_from;
    int          exp_fwd1 [2];
    int          exp_fwd2 [2];
    logic [31:0] exp_cnt [2];
    logic        prev_stall_a;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int depth_of(input int inst);
        return (inst == 0) ? D_A : D_B;
    endfunction

    function automatic int lstage_of(input int inst);
        return (inst == 0) ? L_A : L_B;
    endfunction

    // Age in cycles of the youngest still-tracked producer of src (0 = none).
    function automatic int producer_age(input int inst, input logic [4:0] src, input logic used);
        if (!used) return 0;
        for (int age = 1; age <= depth_of(inst); age++) begin
            int d;
            d = cyc - age;
            if (d >= valid_from && hist[inst][d].wr && hist[inst][d].rd == src) return age;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_inflight(input int inst);
        logic [31:0] m;
        m = '0;
        for (int k = 1; k <= depth_of(inst); k++) begin
            if (cyc - k >= valid_from && hist[inst][cyc-k].wr) m[k-1] = 1'b1;
        end
        return m;
    endfunction

    task automatic check_regs(input int inst, input string nm, input logic [31:0] inf,
                              input logic [31:0] f1, input logic [31:0] f2, input logic [31:0] cnt);
        check({nm, ".inflight"}, inf, model_inflight(inst));
        check({nm, ".ex_fwd_rs1"}, f1, exp_fwd1[inst]);
        check({nm, ".ex_fwd_rs2"}, f2, exp_fwd2[inst]);
        check({nm, ".stall_cnt"}, cnt, exp_cnt[inst]);
    endtask

    task automatic eval_inst(input int inst, input string nm, input logic got_stall,
                             input logic got_b1, input logic got_b2);
        int   a1, a2, d, l;
        logic ld1, ld2, hz, st, issue;
        d   = depth_of(inst);
        l   = lstage_of(inst);
        a1  = producer_age(inst, id_rs1, id_rs1_used);
        a2  = producer_age(inst, id_rs2, id_rs2_used);
        ld1 = (a1 != 0) && hist[inst][cyc-a1].ld;
        ld2 = (a2 != 0) && hist[inst][cyc-a2].ld;
        if (FWD) hz = (ld1 && a1 < l) || (ld2 && a2 < l);
        else     hz = (a1 != 0 && a1 < d) || (a2 != 0 && a2 < d);
        st = id_valid && !flush && hz;
        check({nm, ".stall"}, got_stall, st);
        check({nm, ".id_bypass_rs1"}, got_b1, a1 == d);
        check({nm, ".id_bypass_rs2"}, got_b2, a2 == d);
        issue = id_valid && !st && !flush;
        hist[inst][cyc].wr = issue && id_reg_write && (id_rd != 5'd0);
        hist[inst][cyc].rd = id_rd;
        hist[inst][cyc].ld = id_is_load;
        exp_fwd1[inst] = (reset && FWD && issue && a1 != 0 && a1 < d) ? a1 + 1 : 0;
        exp_fwd2[inst] = (reset && FWD && issue && a2 != 0 && a2 < d) ? a2 + 1 : 0;
        if (!reset) exp_cnt[inst] = '0;
        else if (st && exp_cnt[inst] != 32'hFFFF_FFFF) exp_cnt[inst] = exp_cnt[inst] + 1;
        if (inst == 0) prev_stall_a = st;
    endtask

    // Small register range so producers and consumers collide often; 17 stands
    // in for the ecall source index.
    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 8) == 8) ? 5'd17 : 5'($urandom_range(0, 7));
    endfunction

    task automatic drive_inputs();
        reset = ($urandom_range(0, 299) != 0);
        if (id_valid && prev_stall_a && $urandom_range(0, 3) != 0) begin
            flush = ($urandom_range(0, 15) == 0);
        end else begin
            id_valid     = ($urandom_range(0, 7) != 0);
            id_rs1       = pick_reg();
            id_rs2       = pick_reg();
            id_rs1_used  = ($urandom_range(0, 3) != 0);
            id_rs2_used  = ($urandom_range(0, 3) != 0);
            id_rd        = pick_reg();
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_is_load   = ($urandom_range(0, 2) == 0);
            flush        = ($urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        valid_from   = 0;
        prev_stall_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_fwd1[i] = 0;
            exp_fwd2[i] = 0;
            exp_cnt[i]  = '0;
        end
        reset        = 1'b0;
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_rs1_used  = 1'b0;
        id_rs2_used  = 1'b0;
        id_rd        = '0;
        id_reg_write = 1'b0;
        id_is_load   = 1'b0;
        flush        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NCYC; i++) begin
            cyc = i;
            check_regs(0, "A", 32'(inflight_a), 32'(fwd1_a), 32'(fwd2_a), cnt_a);
            check_regs(1, "B", 32'(inflight_b), 32'(fwd1_b), 32'(fwd2_b), cnt_b);
            if (i > 0) drive_inputs();
            #1;
            eval_inst(0, "A", stall_a, byp1_a, byp2_a);
            eval_inst(1, "B", stall_b, byp1_b, byp2_b);
            if (!reset) valid_from = cyc + 1;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
